ex_trap_arbiter: RTL and testbench

//  Collects up to NSRC external interrupt sources. Latches edge/level pending state per source.

---
 rtl/ex_trap_arbiter.sv | 117 +++++++++++
 tb/tb_ex_trap_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_trap_arbiter.sv
// External interrupt collector: per-source edge/level pending latch,
// round-robin grant onto the core's single trap valid/ready handshake.
module ex_trap_arbiter #(
   parameter int unsigned           NSRC     = 8,
   parameter int unsigned           IDW      = $clog2(NSRC),
   parameter logic [NSRC-1:0]       SRC_EDGE = {NSRC{1'b1}}
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NSRC-1:0] src_irq,
   input  logic [NSRC-1:0] irq_en,
   output logic            trap_valid,
   input  logic            trap_ready,
   output logic [IDW-1:0]  trap_id,
   output logic [NSRC-1:0] pending,
   output logic [7:0]      lost_cnt
);

   typedef enum logic {IDLE, REQ} state_t;

   state_t            state_q, state_d;
   logic [NSRC-1:0]   src_d;
   logic [IDW-1:0]    rr_ptr, rr_d;
   logic [IDW-1:0]    id_d;
   logic              valid_d;

   logic              hs;
   logic [NSRC-1:0]   edge_set, clr, lost_vec, pend_d, eligible;
   logic [2*NSRC-1:0] rot;
   logic [IDW-1:0]    off;
   logic              found;
   logic [IDW:0]      sum;
   logic [IDW-1:0]    pick;
   logic [8:0]        lost_sum;
   logic [5:0]        lost_n;

   assign hs       = (state_q == REQ) && trap_ready;
   assign edge_set = src_irq & ~src_d & SRC_EDGE;
   assign clr      = hs ? (SRC_EDGE & (NSRC'(1) << trap_id)) : '0;
   assign lost_vec = edge_set & pending & ~clr;
   assign eligible = pending & irq_en;

   // Edge sources: set beats clear. Level sources just track the pin.
   assign pend_d = (SRC_EDGE & ((pending & ~clr) | edge_set))
                 | (~SRC_EDGE & src_irq);

   always_comb begin
      lost_n = '0;
      for (int i = 0; i < NSRC; i++)
         lost_n = lost_n + 6'(lost_vec[i]);
      lost_sum = {1'b0, lost_cnt} + 9'(lost_n);
   end

   // Rotate so bit 0 is rr_ptr, take the lowest set bit, rotate back.
   always_comb begin
      rot   = {eligible, eligible} >> rr_ptr;
      off   = '0;
      found = 1'b0;
      for (int o = NSRC - 1; o >= 0; o--) begin
         if (rot[o]) begin
            off   = IDW'(o);
            found = 1'b1;
         end
      end
      sum  = {1'b0, rr_ptr} + {1'b0, off};
      pick = (sum >= (IDW+1)'(NSRC)) ? IDW'(sum - (IDW+1)'(NSRC))
                                      : IDW'(sum);
   end

   always_comb begin
      state_d = state_q;
      valid_d = trap_valid;
      id_d    = trap_id;
      rr_d    = rr_ptr;
      unique case (state_q)
         IDLE: begin
            valid_d = 1'b0;
            if (found) begin
               id_d    = pick;
               valid_d = 1'b1;
               state_d = REQ;
            end
         end
         REQ: begin
            valid_d = 1'b1;
            if (trap_ready) begin
               valid_d = 1'b0;
               rr_d    = (trap_id == IDW'(NSRC - 1)) ? '0
                                                     : trap_id + 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         trap_valid <= 1'b0;
         trap_id    <= '0;
         rr_ptr     <= '0;
         src_d      <= '0;
         pending    <= '0;
         lost_cnt   <= '0;
      end else begin
         state_q    <= state_d;
         trap_valid <= valid_d;
         trap_id    <= id_d;
         rr_ptr     <= rr_d;
         src_d      <= src_irq;
         pending    <= pend_d;
         lost_cnt   <= lost_sum[8] ? 8'hFF : lost_sum[7:0];
      end
   end

endmodule

// File: tb/tb_ex_trap_arbiter.sv
// Directed-vector bench for ex_trap_arbiter, NSRC=8 with source 7
// configured as level-triggered and the rest edge-triggered.
module tb_ex_trap_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] src_irq;
   logic [7:0] irq_en;
   logic       trap_valid;
   logic       trap_ready;
   logic [2:0] trap_id;
   logic [7:0] pending;
   logic [7:0] lost_cnt;

   int n_vec = 0;
   int n_bad = 0;

   ex_trap_arbiter #(
      .NSRC     (8),
      .IDW      (3),
      .SRC_EDGE (8'h7F)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .src_irq    (src_irq),
      .irq_en     (irq_en),
      .trap_valid (trap_valid),
      .trap_ready (trap_ready),
      .trap_id    (trap_id),
      .pending    (pending),
      .lost_cnt   (lost_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   logic [2:0] ids3 [3] = '{3'd1, 3'd5, 3'd6};
   logic [2:0] ids2 [2] = '{3'd1, 3'd5};

   initial begin
      rst_n      = 1'b0;
      src_irq    = '0;
      irq_en     = 8'hFF;
      trap_ready = 1'b0;
      tick();
      tick();
      chk("rst_valid", 32'(trap_valid), 0);
      chk("rst_id", 32'(trap_id), 0);
      chk("rst_pend", 32'(pending), 0);
      chk("rst_lost", 32'(lost_cnt), 0);
      rst_n = 1'b1;
      tick();

      // single edge on source 3
      trap_ready = 1'b1;
      src_irq    = 8'h08;
      tick();
      chk("t1_pend_set", 32'(pending), 32'h08);
      chk("t1_no_valid", 32'(trap_valid), 0);
      src_irq = '0;
      tick();
      chk("t1_valid", 32'(trap_valid), 1);
      chk("t1_id", 32'(trap_id), 3);
      tick();
      chk("t1_hs_valid", 32'(trap_valid), 0);
      chk("t1_hs_pend", 32'(pending), 0);
      chk("t1_lost", 32'(lost_cnt), 0);

      // round robin from rr_ptr=0
      do_reset();
      src_irq = 8'h62;
      tick();
      src_irq = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t2_valid", 32'(trap_valid), 1);
         chk("t2_id", 32'(trap_id), 32'(ids3[i]));
         tick();
         chk("t2_gap", 32'(trap_valid), 0);
      end
      src_irq = 8'h22;
      tick();
      src_irq = '0;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("t2w_valid", 32'(trap_valid), 1);
         chk("t2w_id", 32'(trap_id), 32'(ids2[i]));
         tick();
         chk("t2w_gap", 32'(trap_valid), 0);
      end
      chk("t2_pend", 32'(pending), 0);

      // masked source
      irq_en  = 8'h00;
      src_irq = 8'h04;
      tick();
      src_irq = '0;
      tick();
      tick();
      chk("t3_no_valid", 32'(trap_valid), 0);
      chk("t3_pend", 32'(pending), 32'h04);
      irq_en = 8'h04;
      tick();
      chk("t3_valid", 32'(trap_valid), 1);
      chk("t3_id", 32'(trap_id), 2);
      tick();
      chk("t3_hs_valid", 32'(trap_valid), 0);
      chk("t3_hs_pend", 32'(pending), 0);
      irq_en = 8'hFF;

      // stalled ready, mask dropped mid-request
      trap_ready = 1'b0;
      src_irq    = 8'h10;
      tick();
      src_irq = '0;
      tick();
      chk("t4_valid", 32'(trap_valid), 1);
      chk("t4_id", 32'(trap_id), 4);
      irq_en = 8'hEF;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t4_stall", 32'({trap_valid, trap_id}), 32'h0C);
      end
      trap_ready = 1'b1;
      tick();
      chk("t4_hs_valid", 32'(trap_valid), 0);
      chk("t4_hs_pend", 32'(pending), 0);
      irq_en = 8'hFF;

      // lost edges on source 0
      trap_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         src_irq = 8'h01;
         tick();
         src_irq = '0;
         tick();
      end
      chk("t5_lost", 32'(lost_cnt), 2);
      chk("t5_valid", 32'(trap_valid), 1);
      chk("t5_id", 32'(trap_id), 0);
      trap_ready = 1'b1;
      tick();
      chk("t5_hs_valid", 32'(trap_valid), 0);
      chk("t5_hs_pend", 32'(pending), 0);
      tick();
      chk("t5_one_grant", 32'(trap_valid), 0);
      tick();
      chk("t5_one_grant2", 32'(trap_valid), 0);

      // reset mid-request, level source 7 re-requests
      trap_ready = 1'b0;
      src_irq    = 8'h80;
      tick();
      chk("t6_level_pend", 32'(pending), 32'h80);
      tick();
      chk("t6_valid", 32'(trap_valid), 1);
      chk("t6_id", 32'(trap_id), 7);
      rst_n = 1'b0;
      tick();
      chk("t6_rst_valid", 32'(trap_valid), 0);
      chk("t6_rst_pend", 32'(pending), 0);
      chk("t6_rst_lost", 32'(lost_cnt), 0);
      rst_n = 1'b1;
      tick();
      chk("t6_pend_back", 32'(pending), 32'h80);
      chk("t6_idle", 32'(trap_valid), 0);
      tick();
      chk("t6_rereq", 32'(trap_valid), 1);
      chk("t6_reid", 32'(trap_id), 7);
      trap_ready = 1'b1;
      tick();
      chk("t6_hs_valid", 32'(trap_valid), 0);
      chk("t6_level_keep", 32'(pending), 32'h80);
      src_irq = '0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
